regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised successor to the processor's 32x32 register file. Adds configurable data width and depth, an optional hardwired zero register, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for multi-cycle producers such as a multiplier/divider. The processor's decode stage uses the busy bits to stall until a pending result has been written back.

## Interface
- DATA_WIDTH, default 32: width of each register and of the data ports.
- ADDR_WIDTH, default 5: register address width; DEPTH = 2**ADDR_WIDTH.
- ZERO_REG, default 1: 1 = register 0 always reads 0 and ignores writes and issues.
- BYPASS, default 1: 1 = a same-cycle write is forwarded to matching read ports.

Ports (reset is asynchronous, active-high; clock is `clock`):
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- ctrl_writeEnable  in  1  write strobe.
- ctrl_writeReg  in  ADDR_WIDTH  write address.
- data_writeReg  in  DATA_WIDTH  write data.
- ctrl_readRegA, ctrl_readRegB  in  ADDR_WIDTH  read addresses.
- data_readRegA, data_readRegB  out  DATA_WIDTH  read data (combinational).
- ctrl_issueEnable  in  1  mark a register as having an in-flight producer.
- ctrl_issueReg  in  ADDR_WIDTH  register to mark busy.
- ctrl_flush  in  1  clear all busy bits (pipeline flush).
- busy_readRegA, busy_readRegB  out  1  busy status of the read addresses.
- busy_count  out  ADDR_WIDTH+1  number of busy registers.

## Operation
- Storage: DEPTH x DATA_WIDTH registers, plus a DEPTH-bit busy vector.
- Reset: all registers and all busy bits go to 0 immediately. All outputs read 0 while reset is high. Reset overrides any in-flight operation.
- Write: at a clock edge with ctrl_writeEnable=1, reg[ctrl_writeReg] takes data_writeReg and busy[ctrl_writeReg] clears.
  - If ZERO_REG=1, a write to address 0 is dropped entirely.
- Issue: at a clock edge with ctrl_issueEnable=1, busy[ctrl_issueReg] is set.
  - If ZERO_REG=1, an issue to address 0 is ignored.
- Issue and write to the same address in the same cycle: the data is written and the busy bit ends at 1, because the newer producer wins.
- Flush: at a clock edge with ctrl_flush=1, every busy bit goes to 0, including any issue in the same cycle. A write in the same cycle still updates the data.
- Read (each port, combinational):
  - If BYPASS=1, ctrl_writeEnable=1, ctrl_writeReg equals the read address, and the address is a writable register: output data_writeReg.
  - Otherwise output reg[address].
  - With ZERO_REG=1, address 0 always reads 0.
- Busy (each port): busy[address], masked to 0 when the bypass condition above holds for that port.
  - With BYPASS=0 the mask does not apply.
  - With ZERO_REG=1, address 0 always reports not busy.
- busy_count: population count of the registered busy vector. Range is 0..DEPTH, or 0..DEPTH-1 when ZERO_REG=1. It cannot overflow.
- Both read ports are independent and may address the same register.

## Timing
- Write latency:
  - BYPASS=1: data is visible on a matching read port in the same cycle it is presented, and from reg[] after the edge.
  - BYPASS=0: data is visible on the first cycle after the edge.
- Issue latency: the busy bit is visible on busy_readRegX and busy_count in the cycle after the edge.
- Flush latency: busy_count=0 in the cycle after the edge.
- The only state elements are the register array and the busy vector. Every output is combinational from that state and the current inputs.
- Reset deasserted mid-cycle: the first write takes effect at the first rising edge after deassertion.

## Test plan
- Reset, then write reg5=0xDEADBEEF, then read A=5 on the next cycle -> 0xDEADBEEF. Write to reg0=0x1234, then read A=0 -> 0 (ZERO_REG=1).
- BYPASS=1: present a write to reg7=0xA5A5A5A5 while A=7, B=7 -> both ports show 0xA5A5A5A5 in that cycle. With BYPASS=0, the ports show the old value 0 until the next cycle.
- Issue reg3 -> next cycle busy_readRegA(A=3)=1 and busy_count=1. A write to reg3 with 0x55 -> next cycle busy=0, data=0x55, busy_count=0.
- Issue and write reg9 in the same cycle -> next cycle data=write value, busy[9]=1. Then issue reg1, reg2, reg4 and flush with a simultaneous issue to reg6 -> next cycle busy_count=0.
- Fill all writable registers with their own index, then assert reset mid-sequence -> all reads return 0 and busy_count=0 immediately, without waiting for a clock edge.
- DATA_WIDTH=16, ADDR_WIDTH=3: write reg7=0xFFFF -> reads 0xFFFF. Issue all 7 writable registers -> busy_count=7.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with an optional hardwired zero register, optional write-to-read bypass,
// and a per-register busy scoreboard that the decode stage uses to stall on in-flight producers.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_issueEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
  input  logic                  ctrl_flush,
  output logic                  busy_readRegA,
  output logic                  busy_readRegB,
  output logic [ADDR_WIDTH:0]   busy_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_reg [DEPTH];
  logic [DEPTH-1:0]      busy_vec;

  logic wr_hit;
  logic issue_hit;
  logic zero_a;
  logic zero_b;
  logic bypass_a;
  logic bypass_b;

  // A request aimed at the hardwired zero register is treated as if it never happened.
  assign wr_hit    = ctrl_writeEnable && !(ZERO_REG && (ctrl_writeReg == '0));
  assign issue_hit = ctrl_issueEnable && !(ZERO_REG && (ctrl_issueReg == '0));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic                  wr_sel;
      logic                  issue_sel;
      logic [DATA_WIDTH-1:0] data_reg;
      logic                  busy_reg;

      assign wr_sel    = wr_hit && (ctrl_writeReg == ADDR_WIDTH'(gi));
      assign issue_sel = issue_hit && (ctrl_issueReg == ADDR_WIDTH'(gi));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          data_reg <= '0;
        end else if (wr_sel) begin
          data_reg <= data_writeReg;
        end
      end

      // Flush beats everything; a same-cycle issue beats the write-back because it is the newer producer.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          busy_reg <= 1'b0;
        end else if (ctrl_flush) begin
          busy_reg <= 1'b0;
        end else if (issue_sel) begin
          busy_reg <= 1'b1;
        end else if (wr_sel) begin
          busy_reg <= 1'b0;
        end
      end

      assign regs_reg[gi] = data_reg;
      assign busy_vec[gi] = busy_reg;
    end
  endgenerate

  assign zero_a   = ZERO_REG && (ctrl_readRegA == '0);
  assign zero_b   = ZERO_REG && (ctrl_readRegB == '0);
  assign bypass_a = BYPASS && wr_hit && (ctrl_writeReg == ctrl_readRegA);
  assign bypass_b = BYPASS && wr_hit && (ctrl_writeReg == ctrl_readRegB);

  // Outputs are forced low during reset so the bypass path cannot leak the write bus.
  always_comb begin
    data_readRegA = '0;
    busy_readRegA = 1'b0;
    if (!reset && !zero_a) begin
      if (bypass_a) begin
        data_readRegA = data_writeReg;
      end else begin
        data_readRegA = regs_reg[ctrl_readRegA];
        busy_readRegA = busy_vec[ctrl_readRegA];
      end
    end
  end

  always_comb begin
    data_readRegB = '0;
    busy_readRegB = 1'b0;
    if (!reset && !zero_b) begin
      if (bypass_b) begin
        data_readRegB = data_writeReg;
      end else begin
        data_readRegB = regs_reg[ctrl_readRegB];
        busy_readRegB = busy_vec[ctrl_readRegB];
      end
    end
  end

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count = busy_count + (ADDR_WIDTH + 1)'(busy_vec[i]);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Checks regfile_scoreboard against an array-based model (32x32, zero reg, bypass) plus directed
// checks on a 16-bit, 8-entry instance without bypass.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        ctrl_writeEnable = 1'b0;
  logic [4:0]  ctrl_writeReg = '0;
  logic [31:0] data_writeReg = '0;
  logic [4:0]  ctrl_readRegA = '0;
  logic [4:0]  ctrl_readRegB = '0;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        ctrl_issueEnable = 1'b0;
  logic [4:0]  ctrl_issueReg = '0;
  logic        ctrl_flush = 1'b0;
  logic        busy_readRegA;
  logic        busy_readRegB;
  logic [5:0]  busy_count;

  logic        s_we = 1'b0;
  logic [2:0]  s_wr = '0;
  logic [15:0] s_wd = '0;
  logic [2:0]  s_ra = '0;
  logic [15:0] s_da;
  logic [15:0] s_db;
  logic        s_ie = 1'b0;
  logic [2:0]  s_ir = '0;
  logic        s_fl = 1'b0;
  logic        s_ba;
  logic        s_bb;
  logic [3:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_reg [32];
  bit          m_busy [32];

  always #5 clock = ~clock;

  regfile_scoreboard u_dut (
    .clock(clock), .reset(reset),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .ctrl_issueEnable(ctrl_issueEnable), .ctrl_issueReg(ctrl_issueReg), .ctrl_flush(ctrl_flush),
    .busy_readRegA(busy_readRegA), .busy_readRegB(busy_readRegB), .busy_count(busy_count)
  );

  regfile_scoreboard #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_small (
    .clock(clock), .reset(reset),
    .ctrl_writeEnable(s_we), .ctrl_writeReg(s_wr), .data_writeReg(s_wd),
    .ctrl_readRegA(s_ra), .ctrl_readRegB(s_ra),
    .data_readRegA(s_da), .data_readRegB(s_db),
    .ctrl_issueEnable(s_ie), .ctrl_issueReg(s_ir), .ctrl_flush(s_fl),
    .busy_readRegA(s_ba), .busy_readRegB(s_bb), .busy_count(s_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input logic we,
                                           input logic [4:0] wr, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wr == a) return wd;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input logic we, input logic [4:0] wr);
    if (a == 0) return 1'b0;
    if (we && wr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [31:0] exp_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One clock cycle on the main instance: drive, check mid-cycle, then advance the model at the edge.
  task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb,
                      input logic ie, input logic [4:0] ir, input logic fl);
    ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
    ctrl_readRegA = ra; ctrl_readRegB = rb;
    ctrl_issueEnable = ie; ctrl_issueReg = ir; ctrl_flush = fl;
    @(negedge clock);
    check("data_a", data_readRegA, exp_data(ra, we, wr, wd));
    check("data_b", data_readRegB, exp_data(rb, we, wr, wd));
    check("busy_a", {31'b0, busy_readRegA}, {31'b0, exp_busy(ra, we, wr)});
    check("busy_b", {31'b0, busy_readRegB}, {31'b0, exp_busy(rb, we, wr)});
    check("busy_count", {26'b0, busy_count}, exp_count());
    $display("step we=%0d wr=%0d wd=%h ra=%0d rb=%0d ie=%0d ir=%0d fl=%0d -> a=%h b=%h cnt=%0d",
             we, wr, wd, ra, rb, ie, ir, fl, data_readRegA, data_readRegB, busy_count);
    @(posedge clock);
    if (we && wr != 0) begin
      m_reg[wr] = wd;
      m_busy[wr] = 1'b0;
    end
    if (ie && ir != 0) m_busy[ir] = 1'b1;
    if (fl) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    #1;
  endtask

  task automatic s_drive(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                         input logic [2:0] ra, input logic ie, input logic [2:0] ir);
    s_we = we; s_wr = wr; s_wd = wd; s_ra = ra; s_ie = ie; s_ir = ir; s_fl = 1'b0;
    @(negedge clock);
    $display("small we=%0d wr=%0d wd=%h ra=%0d ie=%0d ir=%0d -> a=%h busy=%0d cnt=%0d",
             we, wr, wd, ra, ie, ir, s_da, s_ba, s_cnt);
  endtask

  task automatic s_tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [4:0]  wr, ra, rb, ir;
    model_clear();

    // Reset held: outputs are zero even with a bypass-matching write presented.
    #1;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'hCAFEF00D;
    ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd3;
    #1;
    check("rst_data_a", data_readRegA, 32'h0);
    check("rst_busy_a", {31'b0, busy_readRegA}, 32'h0);
    check("rst_count", {26'b0, busy_count}, 32'h0);
    ctrl_writeEnable = 1'b0;
    #10 reset = 1'b0;
    @(posedge clock); #1;

    // Directed sequence from the test plan.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 5, 5, 0, 0, 0);
    check("reg5_value", data_readRegA, 32'hDEADBEEF);
    step(1, 0, 32'h1234, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 5, 0, 0, 0);
    step(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, 0);
    step(0, 0, 0, 3, 7, 1, 3, 0);
    step(0, 0, 0, 3, 3, 0, 0, 0);
    check("busy3_set", {31'b0, busy_readRegA}, 32'h1);
    step(1, 3, 32'h55, 3, 3, 0, 0, 0);
    step(0, 0, 0, 3, 3, 0, 0, 0);
    step(1, 9, 32'h99999999, 9, 0, 1, 9, 0);
    step(0, 0, 0, 9, 9, 1, 1, 0);
    step(0, 0, 0, 9, 1, 1, 2, 0);
    step(0, 0, 0, 2, 1, 1, 4, 0);
    step(0, 0, 0, 4, 6, 1, 6, 1);
    step(0, 0, 0, 6, 9, 0, 0, 0);
    check("flush_count", {26'b0, busy_count}, 32'h0);

    // Random traffic, biased toward a few registers so collisions happen often.
    for (int n = 0; n < 400; n++) begin
      wr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      ir = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), wr, $urandom, ra, rb,
           1'($urandom_range(0, 1)), ir, 1'($urandom_range(0, 15) == 0));
    end

    // Fill every writable register with its index, then reset mid-cycle.
    for (int a = 1; a < 32; a++) begin
      step(1, 5'(a), 32'(a), 5'(a - 1), 5'(31), 1, 5'(32 - a), 0);
    end
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hFFFFFFFF;
    ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd31; ctrl_issueEnable = 1'b0; ctrl_flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_a", data_readRegA, 32'h0);
    check("async_rst_b", data_readRegB, 32'h0);
    check("async_rst_busy_b", {31'b0, busy_readRegB}, 32'h0);
    check("async_rst_count", {26'b0, busy_count}, 32'h0);
    ctrl_writeEnable = 1'b0;
    model_clear();
    #8 reset = 1'b0;
    @(posedge clock); #1;
    step(0, 0, 0, 31, 17, 0, 0, 0);
    step(1, 12, 32'h0BADCAFE, 12, 1, 0, 0, 0);
    step(0, 0, 0, 12, 2, 0, 0, 0);

    // Narrow instance without bypass.
    s_drive(1, 7, 16'hFFFF, 7, 0, 0);
    check("s_nobypass", {16'b0, s_da}, 32'h0);
    s_tick();
    s_drive(0, 0, 0, 7, 0, 0);
    check("s_reg7", {16'b0, s_da}, 32'hFFFF);
    check("s_reg7_b", {16'b0, s_db}, 32'hFFFF);
    s_tick();
    s_drive(0, 0, 0, 7, 1, 7);
    check("s_busy_pre", {31'b0, s_ba}, 32'h0);
    s_tick();
    s_drive(1, 7, 16'h1234, 7, 0, 0);
    check("s_busy_nomask", {31'b0, s_ba}, 32'h1);
    check("s_old_data", {16'b0, s_da}, 32'hFFFF);
    s_tick();
    s_drive(0, 0, 0, 7, 0, 0);
    check("s_new_data", {16'b0, s_da}, 32'h1234);
    check("s_busy_clear", {31'b0, s_ba}, 32'h0);
    check("s_count0", {28'b0, s_cnt}, 32'h0);
    s_tick();
    for (int a = 0; a < 8; a++) begin
      s_drive(0, 0, 0, 0, 1, 3'(a));
      s_tick();
    end
    s_drive(0, 0, 0, 0, 0, 0);
    check("s_count7", {28'b0, s_cnt}, 32'h7);
    check("s_zero_busy", {31'b0, s_ba}, 32'h0);
    check("s_zero_data", {16'b0, s_da}, 32'h0);
    s_tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
